// File: rtl/mcounter_if.sv
// Signal bundle for one emulated counter stage: emulated clock/control inputs
// and the counter value / cascade outputs.
interface mcounter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             ck;
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             edge_o;
  logic             wrap;

  modport master (
    output ck, clr, ld, d, en, up,
    input  q, tc, edge_o, wrap
  );

  modport slave (
    input  ck, clr, ld, d, en, up,
    output q, tc, edge_o, wrap
  );
endinterface

// File: rtl/mcounter.sv
// Edge-triggered 74x161/163-style counter emulated in the `clock` domain:
// the derived net `ck` is sampled and edge-detected instead of clocking flops.
module mcounter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16,
  parameter bit          EDGE    = 1'b1
) (
  input logic       clock,
  input logic       resb,
  mcounter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ck_prev;
  logic             wrap_q;
  logic             wrap_nxt;
  logic             edge_c;

  // ck_prev resets to the active level so a ck already active at release is not an edge
  assign edge_c = EDGE ? (bus.ck & ~ck_prev) : (~bus.ck & ck_prev);

  // Next-state: clear > load > count > hold
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (bus.clr) begin
      cnt_nxt = CNT_ZERO;
    end else if (edge_c && bus.ld) begin
      cnt_nxt = bus.d;
    end else if (edge_c && bus.en) begin
      if (bus.up) begin
        if (cnt >= CNT_MAX) begin
          cnt_nxt  = CNT_ZERO;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (cnt == CNT_ZERO) begin
          cnt_nxt  = CNT_MAX;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resb) begin
    if (!resb) begin
      cnt     <= CNT_ZERO;
      wrap_q  <= 1'b0;
      ck_prev <= EDGE;
    end else begin
      cnt     <= cnt_nxt;
      wrap_q  <= wrap_nxt;
      ck_prev <= bus.ck;
    end
  end

  // clr behaves like the original async clear: zero latency on q/tc/edge_o
  assign bus.q      = bus.clr ? CNT_ZERO : cnt;
  assign bus.tc     = ~bus.clr & bus.en & (bus.up ? (cnt == CNT_MAX) : (cnt == CNT_ZERO));
  assign bus.edge_o = edge_c & ~bus.clr;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_mcounter.sv
// Self-checking bench for mcounter: directed scenarios plus randomized stimulus
// against an integer reference model (EDGE=1 and EDGE=0 instances, two-stage cascade).
module tb_mcounter;

  localparam int unsigned W = 4;
  localparam int          M = 10;

  logic       clock = 1'b0;
  logic       resb;
  logic       ck, clr, ld, en, up;
  logic [3:0] d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mcounter_if #(.WIDTH(W)) bus_a ();
  mcounter_if #(.WIDTH(W)) bus_b ();
  mcounter_if #(.WIDTH(W)) bus0 ();
  mcounter_if #(.WIDTH(W)) bus1 ();

  assign bus_a.ck = ck;  assign bus_a.clr = clr; assign bus_a.ld = ld;
  assign bus_a.d  = d;   assign bus_a.en  = en;  assign bus_a.up = up;
  assign bus_b.ck = ck;  assign bus_b.clr = clr; assign bus_b.ld = ld;
  assign bus_b.d  = d;   assign bus_b.en  = en;  assign bus_b.up = up;
  assign bus0.ck  = ck;  assign bus0.clr  = 1'b0; assign bus0.ld = 1'b0;
  assign bus0.d   = '0;  assign bus0.en   = 1'b1; assign bus0.up = 1'b1;
  assign bus1.ck  = ck;  assign bus1.clr  = 1'b0; assign bus1.ld = 1'b0;
  assign bus1.d   = '0;  assign bus1.en   = bus0.tc; assign bus1.up = 1'b1;

  mcounter #(.WIDTH(W), .MODULUS(M), .EDGE(1'b1)) u_a  (.clock(clock), .resb(resb), .bus(bus_a));
  mcounter #(.WIDTH(W), .MODULUS(M), .EDGE(1'b0)) u_b  (.clock(clock), .resb(resb), .bus(bus_b));
  mcounter #(.WIDTH(W), .MODULUS(M), .EDGE(1'b1)) u_s0 (.clock(clock), .resb(resb), .bus(bus0));
  mcounter #(.WIDTH(W), .MODULUS(M), .EDGE(1'b1)) u_s1 (.clock(clock), .resb(resb), .bus(bus1));

  // Reference model: index 0 = rising-edge counter, 1 = falling-edge counter
  int m_cnt[2];
  int m_wrap[2];
  int m_prev[2];
  int cas_prev;
  int cas_edges;

  int obs_q, obs_tc, obs_edge, obs_wrap, obs_qb;
  int wrap_seen, edge_seen;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_edge(input int i);
    if (i == 0) return (ck && m_prev[0] == 0) ? 1 : 0;
    return (!ck && m_prev[1] == 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 0;
    end
    m_prev[0] = 1;
    m_prev[1] = 0;
    cas_prev  = 1;
    cas_edges = 0;
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int e;
      e = model_edge(i);
      m_prev[i] = ck ? 1 : 0;
      if (clr) begin
        m_cnt[i] = 0; m_wrap[i] = 0;
      end else if (e == 1 && ld) begin
        m_cnt[i] = int'(d); m_wrap[i] = 0;
      end else if (e == 1 && en) begin
        if (up) begin
          if (m_cnt[i] >= M - 1) begin m_cnt[i] = 0; m_wrap[i] = 1; end
          else begin m_cnt[i] = m_cnt[i] + 1; m_wrap[i] = 0; end
        end else begin
          if (m_cnt[i] == 0) begin m_cnt[i] = M - 1; m_wrap[i] = 1; end
          else begin m_cnt[i] = m_cnt[i] - 1; m_wrap[i] = 0; end
        end
      end else begin
        m_wrap[i] = 0;
      end
    end
    if (ck && cas_prev == 0) cas_edges++;
    cas_prev = ck ? 1 : 0;
  endtask

  task automatic sample_and_check();
    int gq[2], gtc[2], ge[2], gw[2];
    int xq, xtc, xe;
    gq[0] = int'(bus_a.q); gtc[0] = int'(bus_a.tc); ge[0] = int'(bus_a.edge_o); gw[0] = int'(bus_a.wrap);
    gq[1] = int'(bus_b.q); gtc[1] = int'(bus_b.tc); ge[1] = int'(bus_b.edge_o); gw[1] = int'(bus_b.wrap);
    for (int i = 0; i < 2; i++) begin
      xq  = clr ? 0 : m_cnt[i];
      xtc = (!clr && en && (up ? (m_cnt[i] == M - 1) : (m_cnt[i] == 0))) ? 1 : 0;
      xe  = (!clr && model_edge(i) == 1) ? 1 : 0;
      check(i == 0 ? "q_rise" : "q_fall", gq[i], xq);
      check(i == 0 ? "tc_rise" : "tc_fall", gtc[i], xtc);
      check(i == 0 ? "edge_rise" : "edge_fall", ge[i], xe);
      check(i == 0 ? "wrap_rise" : "wrap_fall", gw[i], m_wrap[i]);
    end
    check("cascade", int'(bus1.q) * 10 + int'(bus0.q), cas_edges % 100);
    obs_q = gq[0]; obs_tc = gtc[0]; obs_edge = ge[0]; obs_wrap = gw[0]; obs_qb = gq[1];
    wrap_seen += gw[0];
    edge_seen += ge[0];
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge
  task automatic step(input logic s_ck, input logic s_clr, input logic s_ld,
                      input logic [3:0] s_d, input logic s_en, input logic s_up);
    ck = s_ck; clr = s_clr; ld = s_ld; d = s_d; en = s_en; up = s_up;
    @(negedge clock);
    sample_and_check();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    resb = 1'b0;
    model_reset();
    #1;
    sample_and_check();
    check("rst_q", obs_q, 0);
    check("rst_wrap", obs_wrap, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    resb = 1'b1;
  endtask

  initial begin
    resb = 1'b0; ck = 1'b0; clr = 1'b0; ld = 1'b0; d = '0; en = 1'b1; up = 1'b1;
    model_reset();
    wrap_seen = 0; edge_seen = 0;
    @(posedge clock); #1;

    // Up count, MODULUS=10, 12 rising edges
    do_reset();
    wrap_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      check("seq_q", obs_q, i % 10);
      check("seq_tc", obs_tc, (i % 10 == 9) ? 1 : 0);
    end
    check("seq_wrap_count", wrap_seen, 1);

    // ck held high through reset release: no edge
    ck = 1'b1;
    do_reset();
    edge_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      check("hold_q", obs_q, 0);
    end
    check("hold_no_edge", edge_seen, 0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("hold_first_edge_q", obs_q, 1);

    // Down count from zero
    ck = 1'b0;
    do_reset();
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("down_tc_at_0", obs_tc, 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check("down_q", obs_q, 9 - k);
      check("down_wrap", obs_wrap, (k == 0) ? 1 : 0);
      check("down_tc", obs_tc, 0);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    end

    // Clear mid-count at q=6
    ck = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("clr_pre_q", obs_q, 6);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    check("clr_q", obs_q, 0);
    check("clr_tc", obs_tc, 0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    check("clr_edge", obs_edge, 0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("clr_rel_edge", obs_edge, 0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("clr_rel_q", obs_q, 0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("clr_next_q", obs_q, 1);

    // Load (en=0), then out-of-range load wrapping up
    step(1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("load5_q", obs_q, 5);
    step(1'b0, 1'b0, 1'b1, 4'd13, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'd13, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("load13_q", obs_q, 13);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("load13_wrap_q", obs_q, 0);
    check("load13_wrap", obs_wrap, 1);

    // Cascade over 25 rising edges; falling-edge instance sees 24
    ck = 1'b0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("cas_stage1", int'(bus1.q), 2);
    check("cas_stage0", int'(bus0.q), 5);
    check("fall_q", obs_qb, 4);

    // ck toggling every clock
    for (int i = 0; i < 40; i++)
      step(ck ? 1'b0 : 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

    // Randomized stimulus against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcounter.md
Name: mcounter

Overview:
- Emulates an edge-triggered gate-level counter (74x161/163-style) in the single `clock` domain.
- The counter's "clock" is a derived net (`ck`). That net is sampled and edge-detected instead of being used as a real clock.
- It is the edge-triggered counterpart of the level-sensitive latch emulation already used in gstmcu. It serves the video/timing counters that the original chip clocks from divided or gated signals.
- Stages cascade through `tc` → `en` of the next stage, as on the original silicon.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2^WIDTH.
- EDGE, 1, active edge of `ck`: 1 = rising, 0 = falling.

Ports:
- clock  in  1  system clock; all state updates on its posedge.
- resb  in  1  asynchronous active-low reset.
- ck  in  1  emulated clock net, synchronous to `clock`.
- clr  in  1  emulated asynchronous clear, active high, level-sensitive.
- ld  in  1  synchronous load, sampled on emulated edge.
- d  in  WIDTH  load value.
- en  in  1  count enable, sampled on emulated edge.
- up  in  1  direction: 1 = up, 0 = down.
- q  out  WIDTH  counter value.
- tc  out  1  terminal count, combinational.
- edge_o  out  1  emulated-edge strobe, combinational.
- wrap  out  1  registered one-cycle pulse after a wrap.

Behaviour:
- **Reset (resb=0, async):**
  - cnt=0, wrap=0.
  - ck_prev=EDGE, so a `ck` already at the active level after reset does not produce an edge.
  - Outputs during reset: q=0; tc per formula with cnt=0; edge_o per formula.
- **Edge detect:**
  - edge = EDGE ? (ck & ~ck_prev) : (~ck & ck_prev).
  - ck_prev <= ck every `clock`.
  - edge_o = edge & ~clr.
- **Priority per `clock` posedge:** clr > (edge & ld) > (edge & en) > hold.
- **clr=1:**
  - cnt <= 0, wrap <= 0, every cycle while asserted.
  - q forced to 0 combinationally in the same cycle clr rises (zero latency, matching async clear).
  - tc=0, edge_o=0.
  - ck_prev keeps tracking `ck`, so no stale edge fires when clr drops.
- **Load:** edge & ld & ~clr → cnt <= d, exactly as given.
  - d ≥ MODULUS is permitted.
  - Load ignores `en`.
  - wrap <= 0.
- **Count up** (edge & en & ~ld & up & ~clr):
  - cnt ≥ MODULUS-1 → cnt <= 0, wrap <= 1.
  - Otherwise cnt <= cnt+1.
- **Count down** (edge & en & ~ld & ~up & ~clr):
  - cnt == 0 → cnt <= MODULUS-1, wrap <= 1.
  - Otherwise cnt <= cnt-1, including out-of-range loaded values.
- **wrap:** high exactly one `clock` cycle, the cycle after the wrapping edge. Otherwise 0.
- **q** = clr ? 0 : cnt. Latency is one `clock` from the edge-sampling posedge.
- **tc** = ~clr & en & (up ? cnt == MODULUS-1 : cnt == 0).
  - Combinational, so a downstream stage sampling the same `ck` edge increments in the same cycle.
- **Arithmetic:** WIDTH-bit, no overflow beyond wrap rules. MODULUS=2^WIDTH gives natural binary wrap.
- **`ck` behaviour:**
  - Held constant: no edges, state holds.
  - `ck` toggling every `clock`: edge every second cycle. Counting must not skip or double.
- **Direction change:** `up` changes are honoured on the next edge only. No pending state.
- **Reset mid-count:** immediate cnt=0 and wrap=0. First edge after release behaves per ck_prev=EDGE.

Test Plan:
- WIDTH=4, MODULUS=10, EDGE=1, en=1, up=1, `ck` toggles every 2 clocks, 12 rising edges → q sequence 1..9,0,1,2; wrap pulses once, 1 clock after the 10th edge; tc=1 only while q=9.
- Hold `ck`=1 through resb release, then keep it high 5 clocks → q stays 0, edge_o never 1; first 0→1 transition gives q=1.
- up=0 from q=0, 3 edges → q=9,8,7; wrap pulses after the first edge; tc=1 only at q=0.
- Assert clr mid-count at q=6 → q=0 in the same cycle, tc=0, edge_o=0 while held; release clr with `ck` high → no count until the next rising edge.
- d=5, ld=1, en=0 on an edge → q=5; d=13 loaded (MODULUS=10), up count → next edge gives q=0 with wrap pulse.
- Two stages with stage0.tc→stage1.en and a shared `ck`, 25 edges → {stage1,stage0}=2,5. EDGE=0 instance counts only on falling transitions.
